// File: rtl/jstk_poll_scheduler_pkg.sv
// Shared types, frame slicing and direction decoding for the joystick poll scheduler.
package jstk_poll_scheduler_pkg;

    localparam int FRAME_W = 40;
    localparam int AXIS_W  = 10;
    localparam int BTN_W   = 3;
    localparam int DIR_W   = 4;
    localparam int ERR_W   = 8;

    // Bit positions inside dir/move: {up, down, left, right}
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_XFER    = 2'd2,
        ST_CAPTURE = 2'd3
    } jstk_state_e;

    function automatic logic [AXIS_W-1:0] frame_x(input logic [FRAME_W-1:0] d);
        return {d[9:8], d[23:16]};
    endfunction

    function automatic logic [AXIS_W-1:0] frame_y(input logic [FRAME_W-1:0] d);
        return {d[25:24], d[39:32]};
    endfunction

    function automatic logic [BTN_W-1:0] frame_btn(input logic [FRAME_W-1:0] d);
        return d[2:0];
    endfunction

    // Threshold-exact values are inactive; compares are done one bit wider than the axis.
    function automatic logic [DIR_W-1:0] raw_dir(input logic [AXIS_W-1:0] x,
                                                 input logic [AXIS_W-1:0] y,
                                                 input int center,
                                                 input int deadzone);
        logic [AXIS_W:0]    hi;
        logic [AXIS_W:0]    lo;
        logic [DIR_W-1:0]   r;
        hi           = (AXIS_W+1)'(center + deadzone);
        lo           = (AXIS_W+1)'(center - deadzone);
        r[DIR_UP]    = {1'b0, y} > hi;
        r[DIR_DOWN]  = {1'b0, y} < lo;
        r[DIR_LEFT]  = {1'b0, x} < lo;
        r[DIR_RIGHT] = {1'b0, x} > hi;
        return r;
    endfunction

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/jstk_poll_scheduler_dir_filter.sv
// Direction debounce: commits a raw direction after it is seen STABLE_N samples in a row,
// and emits move pulses on new bits and every REPEAT_N samples while a bit is held.
module jstk_poll_scheduler_dir_filter
    import jstk_poll_scheduler_pkg::*;
#(
    parameter int STABLE_N = 2,
    parameter int REPEAT_N = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic [DIR_W-1:0] raw,
    input  logic             clear,
    output logic [DIR_W-1:0] dir,
    output logic [DIR_W-1:0] move
);

    localparam int STB_W = $clog2(STABLE_N + 1);
    localparam int REP_W = $clog2(REPEAT_N + 1);

    logic [DIR_W-1:0]            prev_raw_r;
    logic [STB_W-1:0]            stable_cnt_r;
    logic [DIR_W-1:0][REP_W-1:0] rep_cnt_r;
    logic [DIR_W-1:0]            dir_r;
    logic [DIR_W-1:0]            move_r;

    logic [STB_W-1:0]            stable_nxt_s;
    logic                        commit_s;
    logic [DIR_W-1:0]            dir_nxt_s;
    logic [DIR_W-1:0]            move_nxt_s;
    logic [DIR_W-1:0][REP_W-1:0] rep_nxt_s;

    // Next-state for the stability counter, committed direction and repeat counters.
    always_comb begin
        stable_nxt_s = stable_cnt_r;
        if (raw != prev_raw_r) begin
            stable_nxt_s = STB_W'(1);
        end else if (stable_cnt_r < STB_W'(STABLE_N)) begin
            stable_nxt_s = stable_cnt_r + STB_W'(1);
        end else begin
            stable_nxt_s = stable_cnt_r;
        end

        commit_s   = (stable_nxt_s >= STB_W'(STABLE_N)) && (raw != dir_r);
        dir_nxt_s  = commit_s ? raw : dir_r;
        move_nxt_s = {DIR_W{1'b0}};
        rep_nxt_s  = rep_cnt_r;

        for (int i = 0; i < DIR_W; i++) begin
            if (dir_nxt_s[i] && !dir_r[i]) begin
                move_nxt_s[i] = 1'b1;
                rep_nxt_s[i]  = {REP_W{1'b0}};
            end else if (dir_nxt_s[i]) begin
                if (rep_cnt_r[i] == REP_W'(REPEAT_N - 1)) begin
                    move_nxt_s[i] = 1'b1;
                    rep_nxt_s[i]  = {REP_W{1'b0}};
                end else begin
                    move_nxt_s[i] = 1'b0;
                    rep_nxt_s[i]  = rep_cnt_r[i] + REP_W'(1);
                end
            end else begin
                move_nxt_s[i] = 1'b0;
                rep_nxt_s[i]  = {REP_W{1'b0}};
            end
        end
    end

    // Filter state registers; move is a single-cycle pulse following each sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev_raw_r   <= {DIR_W{1'b0}};
            stable_cnt_r <= {STB_W{1'b0}};
            rep_cnt_r    <= {(DIR_W*REP_W){1'b0}};
            dir_r        <= {DIR_W{1'b0}};
            move_r       <= {DIR_W{1'b0}};
        end else if (sample) begin
            prev_raw_r   <= raw;
            stable_cnt_r <= stable_nxt_s;
            rep_cnt_r    <= rep_nxt_s;
            dir_r        <= dir_nxt_s;
            move_r       <= move_nxt_s;
        end else begin
            move_r       <= {DIR_W{1'b0}};
        end
    end

    assign dir  = dir_r;
    assign move = move_r;

endmodule

// File: rtl/jstk_poll_scheduler.sv
// Joystick poll scheduler: periodic SPI start, busy/done handshake with timeouts,
// frame capture into X/Y/buttons and debounced direction output.
module jstk_poll_scheduler
    import jstk_poll_scheduler_pkg::*;
#(
    parameter int POLL_DIV = 5_000_000,
    parameter int CENTER   = 512,
    parameter int DEADZONE = 200,
    parameter int START_TO = 1024,
    parameter int XFER_TO  = 200_000,
    parameter int STABLE_N = 2,
    parameter int REPEAT_N = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               spi_start,
    input  logic               spi_busy,
    input  logic [FRAME_W-1:0] spi_dout,
    output logic [AXIS_W-1:0]  x_pos,
    output logic [AXIS_W-1:0]  y_pos,
    output logic [BTN_W-1:0]   btn,
    output logic               sample_stb,
    output logic [DIR_W-1:0]   dir,
    output logic [DIR_W-1:0]   move,
    output logic               link_ok,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int TICK_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TO_MAX = (START_TO > XFER_TO) ? START_TO : XFER_TO;
    localparam int TO_W   = (TO_MAX > 1) ? $clog2(TO_MAX) : 1;

    jstk_state_e        state_r;
    logic [TICK_W-1:0]  tick_cnt_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic               spi_start_r;
    logic               sample_stb_r;
    logic [AXIS_W-1:0]  x_r;
    logic [AXIS_W-1:0]  y_r;
    logic [BTN_W-1:0]   btn_r;
    logic               link_ok_r;
    logic [ERR_W-1:0]   err_cnt_r;
    logic               enable_q_r;

    logic               tick_s;
    logic               capture_s;
    logic               filt_clear_s;
    logic [DIR_W-1:0]   raw_s;
    logic               unused_frame_bits_s;

    assign tick_s       = (tick_cnt_r == TICK_W'(POLL_DIV - 1));
    assign capture_s    = (state_r == ST_CAPTURE);
    assign filt_clear_s = enable_q_r && !enable;
    assign raw_s        = raw_dir(frame_x(spi_dout), frame_y(spi_dout), CENTER, DEADZONE);
    assign unused_frame_bits_s = ^{spi_dout[31:26], spi_dout[15:10], spi_dout[7:3]};

    // Free-running poll tick divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Previous enable, so the filter is cleared only on the falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q_r <= 1'b0;
        end else begin
            enable_q_r <= enable;
        end
    end

    // Transaction FSM with timeout counter and registered capture outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            to_cnt_r     <= {TO_W{1'b0}};
            spi_start_r  <= 1'b0;
            sample_stb_r <= 1'b0;
            x_r          <= AXIS_W'(CENTER);
            y_r          <= AXIS_W'(CENTER);
            btn_r        <= {BTN_W{1'b0}};
            link_ok_r    <= 1'b0;
            err_cnt_r    <= {ERR_W{1'b0}};
        end else begin
            spi_start_r  <= 1'b0;
            sample_stb_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Ticks arriving in any other state are simply lost.
                    if (tick_s && enable) begin
                        state_r     <= ST_START;
                        spi_start_r <= 1'b1;
                        to_cnt_r    <= {TO_W{1'b0}};
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (spi_busy) begin
                        state_r  <= ST_XFER;
                        to_cnt_r <= {TO_W{1'b0}};
                    end else if (to_cnt_r == TO_W'(START_TO - 1)) begin
                        state_r   <= ST_IDLE;
                        link_ok_r <= 1'b0;
                        err_cnt_r <= err_sat_inc(err_cnt_r);
                    end else begin
                        to_cnt_r  <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_XFER: begin
                    if (!spi_busy) begin
                        state_r   <= ST_CAPTURE;
                    end else if (to_cnt_r == TO_W'(XFER_TO - 1)) begin
                        state_r   <= ST_IDLE;
                        link_ok_r <= 1'b0;
                        err_cnt_r <= err_sat_inc(err_cnt_r);
                    end else begin
                        to_cnt_r  <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    x_r          <= frame_x(spi_dout);
                    y_r          <= frame_y(spi_dout);
                    btn_r        <= frame_btn(spi_dout);
                    sample_stb_r <= 1'b1;
                    link_ok_r    <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    jstk_poll_scheduler_dir_filter #(
        .STABLE_N (STABLE_N),
        .REPEAT_N (REPEAT_N)
    ) u_dir_filter (
        .clk    (clk),
        .rst    (rst),
        .sample (capture_s),
        .raw    (raw_s),
        .clear  (filt_clear_s),
        .dir    (dir),
        .move   (move)
    );

    assign spi_start  = spi_start_r;
    assign sample_stb = sample_stb_r;
    assign x_pos      = x_r;
    assign y_pos      = y_r;
    assign btn        = btn_r;
    assign link_ok    = link_ok_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Scoreboard bench for jstk_poll_scheduler: SPI engine model, behavioural direction model,
// and a monitor comparing every sample_stb against the queued expectation.
module tb_jstk_poll_scheduler;

    localparam int POLL_DIV = 400;
    localparam int CENTER   = 512;
    localparam int DEADZONE = 200;
    localparam int START_TO = 1024;
    localparam int XFER_TO  = 1500;
    localparam int STABLE_N = 2;
    localparam int REPEAT_N = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        spi_start;
    logic        spi_busy;
    logic [39:0] spi_dout;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [2:0]  btn;
    logic        sample_stb;
    logic [3:0]  dir;
    logic [3:0]  move;
    logic        link_ok;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    jstk_poll_scheduler #(
        .POLL_DIV (POLL_DIV), .CENTER (CENTER), .DEADZONE (DEADZONE), .START_TO (START_TO),
        .XFER_TO (XFER_TO), .STABLE_N (STABLE_N), .REPEAT_N (REPEAT_N)
    ) dut (
        .clk (clk), .rst (rst), .enable (enable), .spi_start (spi_start), .spi_busy (spi_busy),
        .spi_dout (spi_dout), .x_pos (x_pos), .y_pos (y_pos), .btn (btn), .sample_stb (sample_stb),
        .dir (dir), .move (move), .link_ok (link_ok), .err_cnt (err_cnt)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
        logic [3:0] d;
        logic [3:0] mv;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural reference state
    logic [3:0] m_prev;
    logic [3:0] m_dir;
    int         m_stable;
    int         m_rep[4];
    logic [7:0] m_err;
    logic [9:0] m_x;

    // SPI model controls
    int         spi_mode = 0;       // 0 normal, 1 never busy, 2 busy stuck
    logic [9:0] nxt_x;
    logic [9:0] nxt_y;
    logic [2:0] nxt_b;
    int         nxt_len = 100;
    bit         abort_txn = 1'b0;
    int         txn_done = 0;
    int         n_start = 0;
    int         mv_cnt[4] = '{0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        m_prev = 4'd0; m_dir = 4'd0; m_stable = 0;
        for (int i = 0; i < 4; i++) m_rep[i] = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_err = 8'd0;
        m_x   = 10'(CENTER);
    endtask

    function automatic logic [39:0] mk_frame(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        logic [39:0] f;
        f = {8'($urandom), 32'($urandom)};
        f[9:8] = x[9:8]; f[23:16] = x[7:0];
        f[25:24] = y[9:8]; f[39:32] = y[7:0];
        f[2:0] = b;
        return f;
    endfunction

    // Apply the direction rules to one captured sample and queue the expected response.
    task automatic model_sample(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        logic [3:0] raw, nd, mv;
        int xi, yi;
        exp_t e;
        xi = int'(x); yi = int'(y);
        raw[3] = yi > CENTER + DEADZONE;
        raw[2] = yi < CENTER - DEADZONE;
        raw[1] = xi < CENTER - DEADZONE;
        raw[0] = xi > CENTER + DEADZONE;
        if (raw == m_prev) m_stable++;
        else m_stable = 1;
        m_prev = raw;
        nd = (m_stable >= STABLE_N && raw != m_dir) ? raw : m_dir;
        mv = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (nd[i] && !m_dir[i]) begin
                mv[i] = 1'b1; m_rep[i] = 0;
            end else if (nd[i]) begin
                m_rep[i]++;
                if (m_rep[i] == REPEAT_N) begin mv[i] = 1'b1; m_rep[i] = 0; end
            end else begin
                m_rep[i] = 0;
            end
        end
        m_dir = nd;
        m_x   = x;
        e = '{x: x, y: y, b: b, d: nd, mv: mv, err: m_err};
        exp_q.push_back(e);
    endtask

    // SPI engine model
    logic [39:0] spi_frame;
    logic [9:0]  spi_x, spi_y;
    logic [2:0]  spi_b;
    logic [7:0]  spi_old_err;
    int          spi_lim;
    initial begin
        spi_busy = 1'b0;
        spi_dout = 40'd0;
        forever begin
            @(posedge clk); #1;
            if (spi_start) begin
                abort_txn = 1'b0;
                if (spi_mode == 1) begin
                    spi_lim = 0;
                end else if (spi_mode == 2) begin
                    spi_old_err = err_cnt;
                    repeat (2) @(posedge clk);
                    #1 spi_busy = 1'b1;
                    spi_lim = 0;
                    while (err_cnt == spi_old_err && spi_lim < 4000) begin
                        @(posedge clk); #1;
                        spi_lim++;
                    end
                    spi_busy = 1'b0;
                end else begin
                    spi_x = nxt_x; spi_y = nxt_y; spi_b = nxt_b;
                    spi_frame = mk_frame(spi_x, spi_y, spi_b);
                    spi_dout = {8'($urandom), 32'($urandom)};
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1 spi_busy = 1'b1;
                    repeat (nxt_len) @(posedge clk);
                    #1;
                    spi_dout = spi_frame;
                    spi_busy = 1'b0;
                    if (!abort_txn) model_sample(spi_x, spi_y, spi_b);
                    txn_done++;
                end
            end
        end
    end

    // Monitor: scoreboard pops on sample_stb, plus protocol checks.
    exp_t e_mon;
    exp_t a_mon;
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_start) n_start++;
            for (int i = 0; i < 4; i++) if (move[i]) mv_cnt[i]++;
            if (spi_start && spi_busy) begin
                n_cmp++; n_bad++;
                $display("FAIL overlap: spi_start=1 while spi_busy=1, expected no start");
            end
            if (sample_stb) begin
                a_mon = '{x: x_pos, y: y_pos, b: btn, d: dir, mv: move, err: err_cnt};
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_stb: sample_stb=1 x=%0d, expected no sample", x_pos);
                end else begin
                    e_mon = exp_q.pop_front();
                    n_cmp++;
                    if (a_mon !== e_mon || link_ok !== 1'b1) begin
                        n_bad++;
                        $display("FAIL sample: got x=%0d y=%0d btn=%0d dir=%b move=%b err=%0d link=%0d, expected x=%0d y=%0d btn=%0d dir=%b move=%b err=%0d link=1",
                                 x_pos, y_pos, btn, dir, move, err_cnt, link_ok,
                                 e_mon.x, e_mon.y, e_mon.b, e_mon.d, e_mon.mv, e_mon.err);
                    end
                end
            end else if (move != 4'd0) begin
                n_cmp++; n_bad++;
                $display("FAIL move_without_stb: move=%b, expected 0000", move);
            end
        end
    end

    task automatic poll(input int x, input int y, input int b, input int len);
        int d0, lim;
        nxt_x = 10'(x); nxt_y = 10'(y); nxt_b = 3'(b); nxt_len = len;
        d0 = txn_done; lim = 0;
        while (txn_done == d0 && lim < 6000) begin @(negedge clk); lim++; end
        if (txn_done == d0) begin
            n_cmp++; n_bad++;
            $display("FAIL poll_wait: no completed transaction in %0d cycles, expected one", lim);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(x_pos), 32'(CENTER));
        chk({tag, "_y"}, 32'(y_pos), 32'(CENTER));
        chk({tag, "_btn"}, 32'(btn), 32'd0);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
        chk({tag, "_move"}, 32'(move), 32'd0);
        chk({tag, "_start"}, 32'(spi_start), 32'd0);
        chk({tag, "_stb"}, 32'(sample_stb), 32'd0);
        chk({tag, "_link"}, 32'(link_ok), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int vals[12] = '{0, 100, 311, 312, 313, 512, 600, 711, 712, 713, 900, 1023};
    int rx, ry, hold, m0, s0, d0, lim;
    logic [7:0] e0;

    initial begin
        rst = 1'b1; enable = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk) rst = 1'b0;

        // Nominal: right commits after two polls
        m0 = mv_cnt[0];
        poll(900, 512, 5, 200);
        poll(900, 512, 5, 200);
        chk("nominal_dir", 32'(dir), 32'd1);
        chk("nominal_x", 32'(x_pos), 32'd900);
        chk("nominal_link", 32'(link_ok), 32'd1);
        chk("nominal_moves", 32'(mv_cnt[0] - m0), 32'd1);

        // Auto-repeat on held left, then release
        m0 = mv_cnt[1];
        for (int k = 0; k < 25; k++) poll(100, 512, k % 8, 30);
        chk("repeat_moves", 32'(mv_cnt[1] - m0), 32'd3);
        chk("repeat_dir", 32'(dir), 32'd2);
        poll(512, 512, 0, 30);
        poll(512, 512, 0, 30);
        chk("release_dir", 32'(dir), 32'd0);
        chk("release_moves", 32'(mv_cnt[1] - m0), 32'd3);

        // Deadzone thresholds
        repeat (3) poll(512, 712, 1, 40);
        chk("dz_712", 32'(dir), 32'd0);
        repeat (3) poll(512, 312, 2, 40);
        chk("dz_312", 32'(dir), 32'd0);
        repeat (2) poll(512, 713, 3, 40);
        chk("dz_713", 32'(dir), 32'd8);

        // Transfers longer than the tick period
        s0 = n_start; d0 = txn_done;
        repeat (3) poll(1023, 0, 6, 900);
        chk("one_start_per_txn", 32'(n_start - s0), 32'(txn_done - d0));

        // Randomised frames
        hold = 0;
        for (int k = 0; k < 40; k++) begin
            if (hold == 0) begin
                rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : vals[$urandom_range(0, 11)];
                ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : vals[$urandom_range(0, 11)];
                hold = $urandom_range(1, 4);
            end
            poll(rx, ry, int'($urandom_range(0, 7)), int'($urandom_range(10, 350)));
            hold--;
        end

        // Enable low clears the filter and blocks new starts
        poll(1023, 512, 0, 50);
        poll(1023, 512, 0, 50);
        @(negedge clk);
        enable = 1'b0;
        model_clear();
        @(posedge clk); #1;
        chk("enable_clear_dir", 32'(dir), 32'd0);
        s0 = n_start;
        repeat (1000) @(negedge clk);
        chk("enable_no_start", 32'(n_start - s0), 32'd0);
        enable = 1'b1;

        // Start timeout: busy never rises
        spi_mode = 1; e0 = err_cnt; lim = 0;
        while (err_cnt == e0 && lim < 3000) begin @(negedge clk); lim++; end
        spi_mode = 0;
        m_err = m_err + 8'd1;
        chk("start_to_err", 32'(err_cnt), 32'(m_err));
        chk("start_to_link", 32'(link_ok), 32'd0);
        chk("start_to_x_held", 32'(x_pos), 32'(m_x));
        chk("start_to_dir_held", 32'(dir), 32'(m_dir));

        // Transfer timeout: busy stuck high
        spi_mode = 2; e0 = err_cnt; lim = 0;
        while (err_cnt == e0 && lim < 4000) begin @(negedge clk); lim++; end
        spi_mode = 0;
        m_err = m_err + 8'd1;
        chk("xfer_to_err", 32'(err_cnt), 32'(m_err));
        chk("xfer_to_link", 32'(link_ok), 32'd0);
        chk("xfer_to_x_held", 32'(x_pos), 32'(m_x));
        poll(300, 800, 4, 60);
        chk("after_to_link", 32'(link_ok), 32'd1);

        // Reset during XFER aborts the transaction
        nxt_x = 10'd1000; nxt_y = 10'd20; nxt_b = 3'd7; nxt_len = 300;
        lim = 0;
        while (!spi_busy && lim < 2000) begin @(negedge clk); lim++; end
        chk("rst_xfer_busy_seen", 32'(spi_busy), 32'd1);
        repeat (50) @(negedge clk);
        abort_txn = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("rst_xfer");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        d0 = txn_done; lim = 0;
        while (txn_done == d0 && lim < 1000) begin @(negedge clk); lim++; end
        repeat (5) @(negedge clk);
        chk("rst_xfer_no_sample", 32'(exp_q.size()), 32'd0);
        chk("rst_xfer_x", 32'(x_pos), 32'(CENTER));

        poll(700, 100, 2, 80);
        poll(700, 100, 2, 80);
        chk("post_rst_dir", 32'(dir), 32'd4);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
